// File: rtl/regroup_read_sched_pkg.sv
// Shared constants for the regroup read scheduler: default bufid width,
// FSM state encoding and the round-robin pick helper.
package regroup_read_sched_pkg;

  localparam int REGROUP_BUFID_W = 9;

  typedef enum logic {
    ST_IDLE      = 1'b0,
    ST_WAIT_DONE = 1'b1
  } sched_state_t;

  // Returns the requester index to grant. Only meaningful when at least one
  // requester is non-empty; with both pending the rr pointer decides.
  function automatic logic rr_pick(input logic ne0, input logic ne1, input logic rr);
    if (ne0 && ne1) return rr;
    return ne1;
  endfunction

endpackage

// File: rtl/regroup_bufid_fifo.sv
// Per-requester bufid FIFO. Depth must be a power of two so the pointers
// wrap for free. Count, full and empty are all registered; full is judged on
// the pre-cycle count, so a write into a full FIFO is dropped even if a pop
// happens in the same cycle.
module regroup_bufid_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 9
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         wr,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] cnt, cnt_n;
  logic          wr_ok, pop_ok;

  assign wr_ok  = wr & ~full;
  assign pop_ok = pop & ~empty;
  assign cnt_n  = cnt + CW'(wr_ok) - CW'(pop_ok);
  assign rdata  = mem[rd_ptr];

  // Pointer/count bookkeeping with registered status flags.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (wr_ok)  wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok) rd_ptr <= rd_ptr + AW'(1);
      cnt   <= cnt_n;
      full  <= (cnt_n == CW'(DEPTH));
      empty <= (cnt_n == '0);
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge i_clk) begin
    if (wr_ok) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/regroup_read_sched.sv
// Regroup read scheduler: two bufid FIFOs (TS / non-TS lanes), round-robin
// arbitration, and one-outstanding-packet issue to the frame reader.
// Optional watchdog: define REGROUP_SCHED_WATCHDOG_EN to abandon a packet
// whose done pulse never arrives within TIMEOUT_CYC cycles.
module regroup_read_sched
  import regroup_read_sched_pkg::*;
#(
  parameter int BUFID_W     = REGROUP_BUFID_W,
  parameter int FIFO_DEPTH  = 4,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [BUFID_W-1:0] iv_bufid0,
  input  logic               i_bufid0_wr,
  output logic               o_fifo0_full,
  input  logic [BUFID_W-1:0] iv_bufid1,
  input  logic               i_bufid1_wr,
  output logic               o_fifo1_full,
  output logic [BUFID_W-1:0] ov_bufid,
  output logic               o_bufid_wr,
  input  logic               i_pkt_last_cycle_valid,
  output logic               o_overflow,
  output logic               o_timeout,
  output logic [15:0]        ov_issue_cnt
);

  sched_state_t       state, state_n;
  logic               rr, rr_n;
  logic               issue, gsel, pop0, pop1, timeout_n;
  logic               empty0, empty1;
  logic [BUFID_W-1:0] head0, head1;

  regroup_bufid_fifo #(.DEPTH(FIFO_DEPTH), .W(BUFID_W)) u_fifo0 (
    .i_clk(i_clk), .i_rst(i_rst), .wr(i_bufid0_wr), .wdata(iv_bufid0),
    .pop(pop0), .rdata(head0), .full(o_fifo0_full), .empty(empty0)
  );

  regroup_bufid_fifo #(.DEPTH(FIFO_DEPTH), .W(BUFID_W)) u_fifo1 (
    .i_clk(i_clk), .i_rst(i_rst), .wr(i_bufid1_wr), .wdata(iv_bufid1),
    .pop(pop1), .rdata(head1), .full(o_fifo1_full), .empty(empty1)
  );

`ifdef REGROUP_SCHED_WATCHDOG_EN
  logic [15:0] wd_cnt;
`endif

  // Arbitration and next-state: grant in IDLE, wait for done (or timeout).
  always_comb begin
    state_n   = state;
    rr_n      = rr;
    issue     = 1'b0;
    gsel      = 1'b0;
    pop0      = 1'b0;
    pop1      = 1'b0;
    timeout_n = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!empty0 || !empty1) begin
          gsel    = rr_pick(!empty0, !empty1, rr);
          issue   = 1'b1;
          pop0    = ~gsel;
          pop1    = gsel;
          rr_n    = ~gsel;
          state_n = ST_WAIT_DONE;
        end
      end
      ST_WAIT_DONE: begin
        if (i_pkt_last_cycle_valid) begin
          state_n = ST_IDLE;
`ifdef REGROUP_SCHED_WATCHDOG_EN
        end else if (wd_cnt == 16'(TIMEOUT_CYC - 1)) begin
          timeout_n = 1'b1;
          state_n   = ST_IDLE;
`endif
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // State, rr pointer and registered issue/status outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state        <= ST_IDLE;
      rr           <= 1'b0;
      ov_bufid     <= '0;
      o_bufid_wr   <= 1'b0;
      o_overflow   <= 1'b0;
      ov_issue_cnt <= '0;
    end else begin
      state      <= state_n;
      rr         <= rr_n;
      o_bufid_wr <= issue;
      o_overflow <= (i_bufid0_wr & o_fifo0_full) | (i_bufid1_wr & o_fifo1_full);
      if (issue) begin
        ov_bufid     <= gsel ? head1 : head0;
        ov_issue_cnt <= ov_issue_cnt + 16'd1;
      end
    end
  end

`ifdef REGROUP_SCHED_WATCHDOG_EN
  // Watchdog: restarts on every grant, counts while waiting for done.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wd_cnt    <= '0;
      o_timeout <= 1'b0;
    end else begin
      o_timeout <= timeout_n;
      if (issue)                     wd_cnt <= '0;
      else if (state == ST_WAIT_DONE) wd_cnt <= wd_cnt + 16'd1;
    end
  end
`else
  assign o_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_regroup_read_sched.sv
// Directed bench for regroup_read_sched: a vector table covering single issue,
// fairness, simultaneous writes and overflow, then hand sequences for the
// long wait (or watchdog) and reset while packets are queued.
module tb_regroup_read_sched;

  logic       i_clk = 1'b0;
  logic       i_rst = 1'b1;
  logic [8:0] iv_bufid0 = '0, iv_bufid1 = '0;
  logic       i_bufid0_wr = 1'b0, i_bufid1_wr = 1'b0;
  logic       i_pkt_last_cycle_valid = 1'b0;
  logic       o_fifo0_full, o_fifo1_full, o_bufid_wr, o_overflow, o_timeout;
  logic [8:0] ov_bufid;
  logic [15:0] ov_issue_cnt;

  int checks = 0;
  int errors = 0;

  regroup_read_sched #(.BUFID_W(9), .FIFO_DEPTH(4), .TIMEOUT_CYC(16)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .iv_bufid0(iv_bufid0), .i_bufid0_wr(i_bufid0_wr), .o_fifo0_full(o_fifo0_full),
    .iv_bufid1(iv_bufid1), .i_bufid1_wr(i_bufid1_wr), .o_fifo1_full(o_fifo1_full),
    .ov_bufid(ov_bufid), .o_bufid_wr(o_bufid_wr),
    .i_pkt_last_cycle_valid(i_pkt_last_cycle_valid),
    .o_overflow(o_overflow), .o_timeout(o_timeout), .ov_issue_cnt(ov_issue_cnt)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic        rst, wr0;
    logic [8:0]  b0;
    logic        wr1;
    logic [8:0]  b1;
    logic        done;
    logic        e_wr;
    logic [8:0]  e_b;
    logic        e_f0, e_f1, e_ovf;
    logic [15:0] e_cnt;
  } vec_t;

  vec_t tbl[48];
  int   nv = 0;

  task automatic add(input logic rst, input logic wr0, input logic [8:0] b0,
                     input logic wr1, input logic [8:0] b1, input logic done,
                     input logic e_wr, input logic [8:0] e_b, input logic e_f0,
                     input logic e_f1, input logic e_ovf, input logic [15:0] e_cnt);
    tbl[nv] = '{rst, wr0, b0, wr1, b1, done, e_wr, e_b, e_f0, e_f1, e_ovf, e_cnt};
    nv++;
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic wr0, input logic [8:0] b0,
                       input logic wr1, input logic [8:0] b1, input logic done);
    i_rst = rst; i_bufid0_wr = wr0; iv_bufid0 = b0;
    i_bufid1_wr = wr1; iv_bufid1 = b1; i_pkt_last_cycle_valid = done;
  endtask

  task automatic idle_step();
    drive(1'b0, 1'b0, 9'h0, 1'b0, 9'h0, 1'b0);
    @(negedge i_clk);
  endtask

  initial begin
    int n;
    int extra;
    // rst wr0 b0 wr1 b1 dn | wr bufid f0 f1 ovf cnt
    add(1,0,9'h00,0,9'h00,0, 0,9'h00,0,0,0,0);   // reset
    add(0,1,9'h05,0,9'h00,0, 0,9'h00,0,0,0,0);   // single bufid write
    add(0,0,9'h00,0,9'h00,0, 1,9'h05,0,0,0,1);   // issued 2 cycles after write
    add(0,0,9'h00,0,9'h00,0, 0,9'h05,0,0,0,1);
    add(0,0,9'h00,0,9'h00,1, 0,9'h05,0,0,0,1);   // done
    add(0,0,9'h00,0,9'h00,0, 0,9'h05,0,0,0,1);
    add(1,0,9'h00,0,9'h00,0, 0,9'h00,0,0,0,0);   // reset -> rr = 0
    add(0,1,9'h10,1,9'h20,0, 0,9'h00,0,0,0,0);   // fairness preload
    add(0,1,9'h11,1,9'h21,0, 1,9'h10,0,0,0,1);
    add(0,0,9'h00,0,9'h00,1, 0,9'h10,0,0,0,1);
    add(0,0,9'h00,0,9'h00,0, 1,9'h20,0,0,0,2);
    add(0,0,9'h00,0,9'h00,1, 0,9'h20,0,0,0,2);
    add(0,0,9'h00,0,9'h00,0, 1,9'h11,0,0,0,3);
    add(0,0,9'h00,0,9'h00,1, 0,9'h11,0,0,0,3);
    add(0,0,9'h00,0,9'h00,0, 1,9'h21,0,0,0,4);
    add(0,0,9'h00,0,9'h00,1, 0,9'h21,0,0,0,4);
    add(0,0,9'h00,0,9'h00,0, 0,9'h21,0,0,0,4);
    add(0,0,9'h00,0,9'h00,1, 0,9'h21,0,0,0,4);   // done while IDLE: ignored
    add(0,1,9'h33,0,9'h00,0, 0,9'h21,0,0,0,4);
    add(0,0,9'h00,0,9'h00,0, 1,9'h33,0,0,0,5);   // rr -> 1
    add(0,0,9'h00,0,9'h00,1, 0,9'h33,0,0,0,5);
    add(0,1,9'h40,1,9'h41,0, 0,9'h33,0,0,0,5);   // simultaneous, rr = 1
    add(0,0,9'h00,0,9'h00,0, 1,9'h41,0,0,0,6);   // requester 1 first
    add(0,0,9'h00,0,9'h00,1, 0,9'h41,0,0,0,6);
    add(0,0,9'h00,0,9'h00,0, 1,9'h40,0,0,0,7);
    add(0,0,9'h00,0,9'h00,1, 0,9'h40,0,0,0,7);
    add(0,0,9'h00,0,9'h00,0, 0,9'h40,0,0,0,7);
    add(0,1,9'h50,0,9'h00,0, 0,9'h40,0,0,0,7);   // overflow sequence
    add(0,1,9'h51,0,9'h00,0, 1,9'h50,0,0,0,8);   // 0x50 issued, now WAIT_DONE
    add(0,1,9'h52,0,9'h00,0, 0,9'h50,0,0,0,8);
    add(0,1,9'h53,0,9'h00,0, 0,9'h50,0,0,0,8);
    add(0,1,9'h54,0,9'h00,0, 0,9'h50,1,0,0,8);   // 4 queued -> full
    add(0,1,9'h55,0,9'h00,0, 0,9'h50,1,0,1,8);   // dropped, overflow pulse
    add(0,0,9'h00,0,9'h00,0, 0,9'h50,1,0,0,8);
    add(0,0,9'h00,0,9'h00,1, 0,9'h50,1,0,0,8);
    add(0,1,9'h56,0,9'h00,0, 1,9'h51,0,0,1,9);   // write+pop while full: dropped
    add(0,0,9'h00,0,9'h00,1, 0,9'h51,0,0,0,9);
    add(0,0,9'h00,0,9'h00,0, 1,9'h52,0,0,0,10);
    add(0,0,9'h00,0,9'h00,1, 0,9'h52,0,0,0,10);
    add(0,0,9'h00,0,9'h00,0, 1,9'h53,0,0,0,11);
    add(0,0,9'h00,0,9'h00,1, 0,9'h53,0,0,0,11);
    add(0,0,9'h00,0,9'h00,0, 1,9'h54,0,0,0,12);
    add(0,0,9'h00,0,9'h00,1, 0,9'h54,0,0,0,12);
    add(0,0,9'h00,0,9'h00,0, 0,9'h54,0,0,0,12);  // 0x55/0x56 never issue

    for (int i = 0; i < nv; i++) begin
      drive(tbl[i].rst, tbl[i].wr0, tbl[i].b0, tbl[i].wr1, tbl[i].b1, tbl[i].done);
      @(negedge i_clk);
      check($sformatf("row%0d bufid_wr", i), 32'(o_bufid_wr), 32'(tbl[i].e_wr));
      check($sformatf("row%0d bufid", i), 32'(ov_bufid), 32'(tbl[i].e_b));
      check($sformatf("row%0d full0", i), 32'(o_fifo0_full), 32'(tbl[i].e_f0));
      check($sformatf("row%0d full1", i), 32'(o_fifo1_full), 32'(tbl[i].e_f1));
      check($sformatf("row%0d overflow", i), 32'(o_overflow), 32'(tbl[i].e_ovf));
      check($sformatf("row%0d issue_cnt", i), 32'(ov_issue_cnt), 32'(tbl[i].e_cnt));
      check($sformatf("row%0d timeout", i), 32'(o_timeout), 32'h0);
    end

    // Queue 4 on requester 1: first issues, 3 remain while waiting for done.
    drive(1'b0, 1'b0, 9'h0, 1'b1, 9'h60, 1'b0); @(negedge i_clk);
    drive(1'b0, 1'b0, 9'h0, 1'b1, 9'h61, 1'b0); @(negedge i_clk);
    check("seq issue 0x60 wr", 32'(o_bufid_wr), 32'h1);
    check("seq issue 0x60 bufid", 32'(ov_bufid), 32'h60);
    drive(1'b0, 1'b0, 9'h0, 1'b1, 9'h62, 1'b0); @(negedge i_clk);
    drive(1'b0, 1'b0, 9'h0, 1'b1, 9'h63, 1'b0); @(negedge i_clk);
    n = 2;

`ifdef REGROUP_SCHED_WATCHDOG_EN
    while (!o_timeout && n < 40) begin
      idle_step();
      n++;
    end
    check("watchdog latency", 32'(n), 32'd16);
    idle_step();
    check("watchdog single pulse", 32'(o_timeout), 32'h0);
    check("post-timeout issue wr", 32'(o_bufid_wr), 32'h1);
    check("post-timeout issue bufid", 32'(ov_bufid), 32'h61);
    check("post-timeout issue_cnt", 32'(ov_issue_cnt), 32'd14);
`else
    extra = 0;
    for (int k = 0; k < 100; k++) begin
      idle_step();
      if (o_bufid_wr || o_timeout) extra++;
    end
    check("no issue while waiting", 32'(extra), 32'd0);
    check("issue_cnt after long wait", 32'(ov_issue_cnt), 32'd13);
`endif

    // Reset with packets outstanding.
    drive(1'b1, 1'b0, 9'h0, 1'b0, 9'h0, 1'b0); @(negedge i_clk);
    check("reset bufid", 32'(ov_bufid), 32'h0);
    check("reset bufid_wr", 32'(o_bufid_wr), 32'h0);
    check("reset full", 32'({o_fifo0_full, o_fifo1_full}), 32'h0);
    check("reset overflow/timeout", 32'({o_overflow, o_timeout}), 32'h0);
    check("reset issue_cnt", 32'(ov_issue_cnt), 32'h0);
    extra = 0;
    for (int k = 0; k < 8; k++) begin
      idle_step();
      if (o_bufid_wr) extra++;
    end
    check("queue discarded by reset", 32'(extra), 32'd0);
    drive(1'b0, 1'b1, 9'h77, 1'b0, 9'h0, 1'b0); @(negedge i_clk);
    check("fresh write not yet issued", 32'(o_bufid_wr), 32'h0);
    idle_step();
    check("fresh issue wr", 32'(o_bufid_wr), 32'h1);
    check("fresh issue bufid", 32'(ov_bufid), 32'h77);
    check("fresh issue_cnt", 32'(ov_issue_cnt), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
